// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin, bounded-hold arbiter that drives the
// one-hot input of the 32-to-5 bus-select encoder. All outputs registered.
// The holder's give-up input is named relinquish because "release" is a
// reserved word in SystemVerilog.
module bus_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] req,
  input  logic        relinquish,
  output logic [31:0] grant,
  output logic        grant_valid,
  output logic [4:0]  grant_idx,
  output logic        timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [4:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [31:0]      grant_nxt;
  logic             valid_nxt;
  logic [4:0]       idx_nxt;
  logic             timeout_nxt;

  logic [4:0]       winner;
  logic             found;
  logic             holder_req;
  logic             hold_max;
  logic             end_grant;

  // Round-robin scan: first requesting source at or above ptr, wrapping 31->0
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && req[ptr + 5'(i)]) begin
        winner = ptr + 5'(i);
        found  = 1'b1;
      end
    end
  end

  // Grant-termination conditions; relinquish outranks withdrawal and timeout
  always_comb begin
    holder_req = req[grant_idx];
    hold_max   = (hold_cnt == HOLD_LIMIT);
    end_grant  = relinquish | ~holder_req | hold_max;
  end

  // State register plus the registered outputs and bookkeeping
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      grant_idx   <= idx_nxt;
      timeout     <= timeout_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  // Next-state logic; every grant returns to IDLE, giving the dead cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (end_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter
  always_comb begin
    grant_nxt   = '0;
    valid_nxt   = 1'b0;
    idx_nxt     = '0;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        hold_nxt = '0;
        if (found) begin
          grant_nxt = 32'd1 << winner;
          valid_nxt = 1'b1;
          idx_nxt   = winner;
          hold_nxt  = CNT_ONE;
        end
      end
      GRANT: begin
        if (end_grant) begin
          ptr_nxt     = grant_idx + 5'd1;
          hold_nxt    = '0;
          timeout_nxt = ~relinquish & holder_req & hold_max;
        end else begin
          grant_nxt = grant;
          valid_nxt = grant_valid;
          idx_nxt   = grant_idx;
          hold_nxt  = hold_cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bus_grant_arbiter.md
Name: bus_grant_arbiter

Overview:
- Sequential front end for the 32-to-5 bus-select encoder.
- Collects up to 32 bus-drive requests from register/ALU/memory sources and issues exactly one one-hot grant at a time.
- Arbitration is round-robin with a bounded hold time.
- grant feeds the encoder input directly; grant_valid qualifies it, because an all-zero grant encodes as source 0.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held before forced release; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- req  input  32  per-source bus request; bit i = source i.
- release  input  1  current holder relinquishes the bus; sampled only in GRANT.
- grant  output  32  registered one-hot grant; all-zero when no grant.
- grant_valid  output  1  high exactly when grant is non-zero.
- grant_idx  output  5  binary index of the granted source; 0 when idle. Diagnostic only.
- timeout  output  1  one-cycle pulse when a grant is ended by MAX_HOLD.

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, grant=0, grant_valid=0, grant_idx=0, timeout=0, ptr=0, hold_cnt=0. Outputs stay at these values while clear is low.
- All outputs are registered. There is no combinational path from req or release to any output.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first set bit of req, scanning upward from ptr and wrapping 31->0.
  - At the next edge: grant=1<<w, grant_idx=w, grant_valid=1, hold_cnt=1, state=GRANT.
  - Latency: req sampled at edge N gives grant visible after edge N (1 cycle).
- GRANT: the grant ends at the next edge on any of the following, in priority order:
  - (a) release=1;
  - (b) req[grant_idx]==0 (requester withdrew);
  - (c) hold_cnt==MAX_HOLD, which also pulses timeout=1 for one cycle.
- Ending a grant:
  - Next state is IDLE with grant=0, grant_valid=0, grant_idx=0.
  - ptr=(w+1) mod 32.
  - One mandatory dead cycle follows every grant (bus turnaround), so back-to-back grants are at least 1 idle cycle apart.
- Otherwise in GRANT: hold_cnt increments and grant is unchanged. New requests from other sources are ignored; no preemption.
- Simultaneous events:
  - release together with timeout counts as release; timeout is not pulsed.
  - req changes during the dead cycle are sampled normally in IDLE.
- Wrap-around:
  - ptr=31 with req bit 31 clear scans 0,1,... .
  - A single persistent requester is re-granted after each dead cycle, with ptr advancing past it.
- Invariants:
  - grant is always 0 or one-hot; never multi-hot.
  - grant_valid==|grant.
  - grant_idx is consistent with grant.
- Reset mid-grant forces outputs to 0 immediately (asynchronously) and ptr to 0.
- release in IDLE has no effect.

Test Plan:
- Reset, then req=32'h0000_0001 -> after 1 edge grant=32'h1, grant_valid=1, grant_idx=0. Release -> grant=0 next edge; ptr=1.
- req=32'h8000_0001 held, release pulsed each grant -> grants alternate 32'h1, 32'h8000_0000, 32'h1, each separated by one idle cycle.
- ptr=5 (after granting source 4), req=32'h0000_0018 -> grant=32'h8 (idx 3, wrap scan 5..31,0..3).
- Single req bit 7 held, no release, MAX_HOLD=16 -> grant held exactly 16 cycles, timeout=1 on the cycle grant drops, then re-grant of bit 7 after one idle cycle.
- Holder drops req[grant_idx] mid-grant while other bits request -> grant=0 at next edge. No other source is granted during the hold; the next winner appears one cycle later.
- Drive clear=0 asynchronously between edges during an active grant -> grant, grant_valid, grant_idx, timeout go 0 without a clock edge. After clear=1 with req=32'h0000_0004 -> grant=32'h4 (ptr restarted at 0).
